pc_fetch_seq: RTL and testbench

//  Program-counter sequencer for the fetch stage. Holds the PC and issues fetches to instruction memory over a req/ack handshake.

---
 rtl/pc_fetch_seq_pkg.sv | 26 ++
 rtl/pc_fetch_seq_if.sv | 33 +++
 rtl/pc_fetch_seq_calc.sv | 54 +++++
 rtl/pc_fetch_seq.sv | 204 ++++++++++++++++++++
 tb/tb_pc_fetch_seq.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_seq_pkg
// Shared definitions for the fetch-stage PC sequencer:
//   DEFAULT_RESET_VECTOR : PC loaded on reset unless overridden
//   WORD_BYTES           : sequential PC increment (one 32-bit instruction)
//   fetch_state_e        : fetch FSM states IDLE / FETCH / SQUASH
//   npc_sel_e            : next-PC source SEQ / BR / JMP
// ---------------------------------------------------------------------------
package pc_fetch_seq_pkg;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int          WORD_BYTES           = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SQUASH = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEQ = 2'd0,
        BR  = 2'd1,
        JMP = 2'd2
    } npc_sel_e;

endpackage

// File: rtl/pc_fetch_seq_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_seq_if
// Instruction-memory fetch handshake between the PC sequencer and imem.
//   req   : fetch request, held high until ack
//   addr  : fetch address (AW bits)
//   ack   : fetch complete, rdata valid this cycle
//   rdata : fetched 32-bit instruction
// Modports: master (sequencer side), slave (memory side).
// ---------------------------------------------------------------------------
interface pc_fetch_seq_if #(
    parameter int AW = 32
) ();

    logic          req;
    logic [AW-1:0] addr;
    logic          ack;
    logic [31:0]   rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/pc_fetch_seq_calc.sv
// ---------------------------------------------------------------------------
// pc_fetch_seq_calc
// Combinational redirect-target calculator for the fetch stage.
//   instr_pc   in  AW  PC of the instruction currently in decode
//   redir      in  1   redirect strobe from decode
//   redir_jump in  1   1 = jump, 0 = conditional branch
//   br_taken   in  1   branch outcome (don't-care for jumps)
//   br_imm     in  16  signed branch offset in words
//   j_idx      in  26  jump instruction index
//   target     out AW  redirect target address
//   sel        out 2   next-PC source (SEQ when no redirect is taken)
// ---------------------------------------------------------------------------
module pc_fetch_seq_calc
    import pc_fetch_seq_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] instr_pc,
    input  logic          redir,
    input  logic          redir_jump,
    input  logic          br_taken,
    input  logic [15:0]   br_imm,
    input  logic [25:0]   j_idx,
    output logic [AW-1:0] target,
    output npc_sel_e      sel
);

    logic [AW-1:0] pcp4;
    logic [AW-1:0] br_off;

    // Both target kinds are relative to the instruction after the one in
    // decode; the branch offset is a word count, so it is sign-extended and
    // scaled to bytes before the add (wraps modulo 2^AW).
    assign pcp4   = instr_pc + AW'(WORD_BYTES);
    assign br_off = {{(AW-18){br_imm[15]}}, br_imm, 2'b00};

    // Jump wins over branch so br_taken never matters for a jump; a branch
    // that is not taken leaves sel at SEQ, which the top reads as "no
    // redirect" and simply ignores the strobe.
    always_comb begin
        sel    = SEQ;
        target = pcp4;
        if (redir) begin
            if (redir_jump) begin
                sel    = JMP;
                target = {pcp4[AW-1:28], j_idx, 2'b00};
            end else if (br_taken) begin
                sel    = BR;
                target = pcp4 + br_off;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_seq.sv
// ---------------------------------------------------------------------------
// pc_fetch_seq
// Program-counter sequencer for the fetch stage. Holds the PC, issues fetches
// to instruction memory over a req/ack handshake and hands fetched
// instructions to the IF/ID register. Decode redirects (jump / taken branch)
// squash the wrong-path fetch.
//   clk           in  1   rising-edge clock
//   reset         in  1   asynchronous active-high reset
//   stall_i       in  1   no new fetch is started while high
//   redir_i       in  1   one-cycle redirect strobe from decode
//   redir_jump_i  in  1   1 = jump, 0 = conditional branch
//   br_taken_i    in  1   branch outcome
//   br_imm_i      in  16  signed branch offset in words
//   j_idx_i       in  26  jump index
//   imem          if      master side of pc_fetch_seq_if (req/addr/ack/rdata)
//   instr_o       out 32  instruction to IF/ID
//   instr_pc_o    out AW  PC of instr_o
//   instr_valid_o out 1   one-cycle strobe, instr_o/instr_pc_o valid
//   pc_o          out AW  current PC
// Build option: define BRANCH_DELAY_SLOT_EN to deliver the fetch following a
// redirect as a delay slot instead of squashing it (SQUASH state unused).
// ---------------------------------------------------------------------------
module pc_fetch_seq
    import pc_fetch_seq_pkg::*;
#(
    parameter int          AW           = 32,
    parameter logic [AW-1:0] RESET_VECTOR = AW'(DEFAULT_RESET_VECTOR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              redir_i,
    input  logic              redir_jump_i,
    input  logic              br_taken_i,
    input  logic [15:0]       br_imm_i,
    input  logic [25:0]       j_idx_i,
    pc_fetch_seq_if.master    imem,
    output logic [31:0]       instr_o,
    output logic [AW-1:0]     instr_pc_o,
    output logic              instr_valid_o,
    output logic [AW-1:0]     pc_o
);

    fetch_state_e  state, state_nxt;
    logic [AW-1:0] pc, pc_nxt;
    logic          outstanding, outstanding_nxt;
    logic [31:0]   instr_nxt;
    logic [AW-1:0] instr_pc_nxt;
    logic          instr_valid_nxt;
    logic          req;
    logic          redirect;
    logic [AW-1:0] target;
    npc_sel_e      sel;
`ifdef BRANCH_DELAY_SLOT_EN
    logic          pend_vld, pend_vld_nxt;
    logic [AW-1:0] pend_pc, pend_pc_nxt;
`else
    logic [AW-1:0] sq_target, sq_target_nxt;
`endif

    pc_fetch_seq_calc #(
        .AW (AW)
    ) u_calc (
        .instr_pc   (instr_pc_o),
        .redir      (redir_i),
        .redir_jump (redir_jump_i),
        .br_taken   (br_taken_i),
        .br_imm     (br_imm_i),
        .j_idx      (j_idx_i),
        .target     (target),
        .sel        (sel)
    );

    assign redirect  = (sel != SEQ);
    assign imem.req  = req;
    assign imem.addr = pc;
    assign pc_o      = pc;

    // State and output registers. Because req is decoded from the state,
    // asserting reset drops it immediately and any late ack lands in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= RESET_VECTOR;
            outstanding   <= 1'b0;
            instr_o       <= '0;
            instr_pc_o    <= '0;
            instr_valid_o <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_vld      <= 1'b0;
            pend_pc       <= '0;
`else
            sq_target     <= '0;
`endif
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            outstanding   <= outstanding_nxt;
            instr_o       <= instr_nxt;
            instr_pc_o    <= instr_pc_nxt;
            instr_valid_o <= instr_valid_nxt;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_vld      <= pend_vld_nxt;
            pend_pc       <= pend_pc_nxt;
`else
            sq_target     <= sq_target_nxt;
`endif
        end
    end

    // Next-state / output logic. A request, once raised, is kept up through
    // 'outstanding' until acked, so stall only prevents starting new fetches.
    // The PC (and therefore addr) only moves on an ack or when no request is
    // in flight, keeping the address stable for the whole handshake.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        outstanding_nxt = outstanding;
        instr_nxt       = instr_o;
        instr_pc_nxt    = instr_pc_o;
        instr_valid_nxt = 1'b0;
        req             = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
        pend_vld_nxt    = pend_vld;
        pend_pc_nxt     = pend_pc;
`else
        sq_target_nxt   = sq_target;
`endif
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                req = !stall_i || outstanding;
`ifdef BRANCH_DELAY_SLOT_EN
                // The fetch completing after a redirect is the delay slot: it
                // is always delivered, and the pending target then replaces
                // the sequential PC.
                if (req && imem.ack) begin
                    instr_nxt       = imem.rdata;
                    instr_pc_nxt    = pc;
                    instr_valid_nxt = 1'b1;
                    outstanding_nxt = 1'b0;
                    pend_vld_nxt    = 1'b0;
                    if (redirect) begin
                        pc_nxt = target;
                    end else if (pend_vld) begin
                        pc_nxt = pend_pc;
                    end else begin
                        pc_nxt = pc + AW'(WORD_BYTES);
                    end
                end else begin
                    outstanding_nxt = req;
                    if (redirect) begin
                        pend_vld_nxt = 1'b1;
                        pend_pc_nxt  = target;
                    end
                end
`else
                // A redirect makes the current fetch wrong-path: drop it if
                // it completes now, or park the target and wait out the
                // in-flight request in SQUASH.
                if (redirect) begin
                    if (req && !imem.ack) begin
                        sq_target_nxt   = target;
                        state_nxt       = SQUASH;
                        outstanding_nxt = 1'b1;
                    end else begin
                        pc_nxt          = target;
                        outstanding_nxt = 1'b0;
                    end
                end else if (req && imem.ack) begin
                    instr_nxt       = imem.rdata;
                    instr_pc_nxt    = pc;
                    instr_valid_nxt = 1'b1;
                    pc_nxt          = pc + AW'(WORD_BYTES);
                    outstanding_nxt = 1'b0;
                end else begin
                    outstanding_nxt = req;
                end
`endif
            end
`ifndef BRANCH_DELAY_SLOT_EN
            SQUASH: begin
                // The wrong-path request must still finish its handshake;
                // its data is thrown away. A newer redirect overrides the
                // parked target.
                req = 1'b1;
                if (imem.ack) begin
                    pc_nxt          = redirect ? target : sq_target;
                    state_nxt       = FETCH;
                    outstanding_nxt = 1'b0;
                end else if (redirect) begin
                    sq_target_nxt = target;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_seq
// Self-checking bench for pc_fetch_seq: a table of redirect vectors applied
// in a loop plus hand-written sequences for sequential fetch, delayed ack,
// squash, redirect-with-ack, wrap and asynchronous reset. A second instance
// with a high reset vector covers jump targets that keep the upper PC nibble.
// Honours BRANCH_DELAY_SLOT_EN for the delay-slot build.
// ---------------------------------------------------------------------------
module tb_pc_fetch_seq;

    typedef struct {
        logic        jump;
        logic        taken;
        logic [15:0] imm;
        logic [25:0] idx;
        logic        redirect;
        logic [31:0] target;
    } redir_vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redir_i;
    logic        redir_jump_i;
    logic        br_taken_i;
    logic [15:0] br_imm_i;
    logic [25:0] j_idx_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic [31:0] pc_o;
    logic [31:0] hi_instr;
    logic [31:0] hi_instr_pc;
    logic        hi_valid;
    logic [31:0] hi_pc;
    int          n_tests = 0;
    int          n_fail  = 0;

    pc_fetch_seq_if #(.AW(32)) imem ();
    pc_fetch_seq_if #(.AW(32)) imem_hi ();

    pc_fetch_seq #(
        .AW           (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .redir_i       (redir_i),
        .redir_jump_i  (redir_jump_i),
        .br_taken_i    (br_taken_i),
        .br_imm_i      (br_imm_i),
        .j_idx_i       (j_idx_i),
        .imem          (imem),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .pc_o          (pc_o)
    );

    pc_fetch_seq #(
        .AW           (32),
        .RESET_VECTOR (32'h9000_0010)
    ) dut_hi (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .redir_i       (redir_i),
        .redir_jump_i  (redir_jump_i),
        .br_taken_i    (br_taken_i),
        .br_imm_i      (br_imm_i),
        .j_idx_i       (j_idx_i),
        .imem          (imem_hi),
        .instr_o       (hi_instr),
        .instr_pc_o    (hi_instr_pc),
        .instr_valid_o (hi_valid),
        .pc_o          (hi_pc)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard stop in case a sequence ever loses its way.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic redir, input logic jump, input logic taken,
                                  input logic [15:0] imm, input logic [25:0] idx);
        redir_i      = redir;
        redir_jump_i = jump;
        br_taken_i   = taken;
        br_imm_i     = imm;
        j_idx_i      = idx;
    endtask

    initial begin
        redir_vec_t  vecs [9];
        logic [31:0] cur_pc;
        logic [31:0] exp_pc;

        vecs[0] = '{jump:1'b1, taken:1'b0, imm:16'h0000, idx:26'h000_0040, redirect:1'b1, target:32'h0000_0100};
        vecs[1] = '{jump:1'b0, taken:1'b1, imm:16'hFFFE, idx:26'h000_0000, redirect:1'b1, target:32'h0000_00FC};
        vecs[2] = '{jump:1'b1, taken:1'b0, imm:16'h0003, idx:26'h3FF_FFFF, redirect:1'b1, target:32'h0FFF_FFFC};
        vecs[3] = '{jump:1'b0, taken:1'b1, imm:16'h7FFF, idx:26'h000_0000, redirect:1'b1, target:32'h1001_FFFC};
        vecs[4] = '{jump:1'b1, taken:1'b1, imm:16'h0007, idx:26'h000_0040, redirect:1'b1, target:32'h1000_0100};
        vecs[5] = '{jump:1'b0, taken:1'b1, imm:16'h8000, idx:26'h000_0000, redirect:1'b1, target:32'h0FFE_0104};
        vecs[6] = '{jump:1'b1, taken:1'b0, imm:16'h0000, idx:26'h000_0000, redirect:1'b1, target:32'h0000_0000};
        vecs[7] = '{jump:1'b0, taken:1'b1, imm:16'hFFFE, idx:26'h000_0000, redirect:1'b1, target:32'hFFFF_FFFC};
        vecs[8] = '{jump:1'b0, taken:1'b0, imm:16'h0005, idx:26'h000_0000, redirect:1'b0, target:32'h0000_0000};

        reset         = 1'b1;
        stall_i       = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        imem.ack      = 1'b0;
        imem.rdata    = '0;
        imem_hi.ack   = 1'b0;
        imem_hi.rdata = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_pc", pc_o, 32'h0);
        check_output("rst_req", {31'b0, imem.req}, 32'h0);
        check_output("rst_valid", {31'b0, instr_valid_o}, 32'h0);
        check_output("rst_instr", instr_o, 32'h0);
        check_output("rst_instr_pc", instr_pc_o, 32'h0);
        check_output("rst_hi_pc", hi_pc, 32'h9000_0010);

        // Jump from 0x9000_0010 keeps the upper nibble; br_taken_i=0.
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        stall_i       = 1'b0;
        imem_hi.ack   = 1'b1;
        imem_hi.rdata = 32'h1234_5678;
        #1;
        check_output("hi_req", {31'b0, imem_hi.req}, 32'h1);
        check_output("hi_addr", imem_hi.addr, 32'h9000_0010);
        @(negedge clk);
        imem_hi.ack = 1'b0;
        stall_i     = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0, 26'h000_0040);
        check_output("hi_valid", {31'b0, hi_valid}, 32'h1);
        check_output("hi_instr_pc", hi_instr_pc, 32'h9000_0010);
        check_output("hi_instr", hi_instr, 32'h1234_5678);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
`ifdef BRANCH_DELAY_SLOT_EN
        check_output("hi_pend_hold", hi_pc, 32'h9000_0014);
        stall_i     = 1'b0;
        imem_hi.ack = 1'b1;
        @(negedge clk);
        imem_hi.ack = 1'b0;
        stall_i     = 1'b1;
        check_output("hi_slot_valid", {31'b0, hi_valid}, 32'h1);
`endif
        check_output("hi_jump_pc", hi_pc, 32'h9000_0100);

        // Sequential fetch with ack every cycle: 0, 4, 8, C.
        @(negedge clk);
        reset   = 1'b1;
        stall_i = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_output("idle_req", {31'b0, imem.req}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("seq_req", {31'b0, imem.req}, 32'h1);
            check_output("seq_addr", imem.addr, 32'(i * 4));
            if (i > 0) begin
                check_output("seq_valid", {31'b0, instr_valid_o}, 32'h1);
                check_output("seq_instr_pc", instr_pc_o, 32'((i - 1) * 4));
                check_output("seq_instr", instr_o, 32'hA000_0000 + 32'(i - 1));
            end
            imem.ack   = 1'b1;
            imem.rdata = 32'hA000_0000 + 32'(i);
        end

        // Ack delayed: request to 0x10 held three cycles, one valid pulse.
        @(negedge clk);
        imem.ack = 1'b0;
        check_output("seq_last_valid", {31'b0, instr_valid_o}, 32'h1);
        check_output("seq_last_pc", instr_pc_o, 32'hC);
        check_output("dly_addr0", imem.addr, 32'h10);
        for (int d = 1; d < 3; d++) begin
            @(negedge clk);
            check_output("dly_req", {31'b0, imem.req}, 32'h1);
            check_output("dly_addr", imem.addr, 32'h10);
            check_output("dly_no_valid", {31'b0, instr_valid_o}, 32'h0);
        end
        imem.ack   = 1'b1;
        imem.rdata = 32'hB0B0_0010;
        @(negedge clk);
        imem.ack = 1'b0;
        stall_i  = 1'b1;
        check_output("dly_valid", {31'b0, instr_valid_o}, 32'h1);
        check_output("dly_instr_pc", instr_pc_o, 32'h10);
        check_output("dly_instr", instr_o, 32'hB0B0_0010);
        @(negedge clk);
        check_output("dly_single", {31'b0, instr_valid_o}, 32'h0);
        check_output("dly_no_refetch", {31'b0, imem.req}, 32'h0);
        check_output("dly_pc", pc_o, 32'h14);

        // Redirect table: fetch one instruction at cur_pc so it sits in
        // decode, then redirect while stalled and check the new PC.
        cur_pc = 32'h14;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            stall_i    = 1'b0;
            imem.ack   = 1'b1;
            imem.rdata = 32'hC000_0000 + 32'(i);
            #1;
            check_output("vec_fetch_addr", imem.addr, cur_pc);
            @(negedge clk);
            imem.ack = 1'b0;
            stall_i  = 1'b1;
            check_output("vec_instr_pc", instr_pc_o, cur_pc);
            apply_stimulus(1'b1, vecs[i].jump, vecs[i].taken, vecs[i].imm, vecs[i].idx);
            @(negedge clk);
            apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
`ifdef BRANCH_DELAY_SLOT_EN
            check_output("vec_pend_hold", pc_o, cur_pc + 32'd4);
            stall_i  = 1'b0;
            imem.ack = 1'b1;
            #1;
            check_output("vec_slot_addr", imem.addr, cur_pc + 32'd4);
            @(negedge clk);
            imem.ack = 1'b0;
            stall_i  = 1'b1;
            check_output("vec_slot_valid", {31'b0, instr_valid_o}, 32'h1);
            exp_pc = vecs[i].redirect ? vecs[i].target : cur_pc + 32'd8;
`else
            check_output("vec_no_valid", {31'b0, instr_valid_o}, 32'h0);
            exp_pc = vecs[i].redirect ? vecs[i].target : cur_pc + 32'd4;
`endif
            check_output($sformatf("vec%0d_pc", i), pc_o, exp_pc);
            cur_pc = exp_pc;
        end

`ifdef BRANCH_DELAY_SLOT_EN
        // Redirect during an outstanding request: that fetch is the delay
        // slot and is delivered, then fetching resumes at the target.
        @(negedge clk);
        stall_i = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b1, 16'hFFFE, 26'h0);
        #1;
        check_output("ds_req", {31'b0, imem.req}, 32'h1);
        check_output("ds_addr", imem.addr, cur_pc);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        check_output("ds_addr_hold", imem.addr, cur_pc);
        imem.ack   = 1'b1;
        imem.rdata = 32'hD5D5_0001;
        @(negedge clk);
        imem.ack = 1'b0;
        check_output("ds_valid", {31'b0, instr_valid_o}, 32'h1);
        check_output("ds_instr_pc", instr_pc_o, cur_pc);
        check_output("ds_target_pc", pc_o, 32'hFFFF_FFFC);
        check_output("ds_target_req", {31'b0, imem.req}, 32'h1);
        cur_pc = 32'hFFFF_FFFC;
`else
        // Redirect during an outstanding request goes through SQUASH; the
        // wrong-path ack yields no valid. Target = 0xFFFF_FFFC+4-8.
        @(negedge clk);
        stall_i = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b1, 16'hFFFE, 26'h0);
        #1;
        check_output("sq_req", {31'b0, imem.req}, 32'h1);
        check_output("sq_addr", imem.addr, 32'h0);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        check_output("sq_req_hold", {31'b0, imem.req}, 32'h1);
        check_output("sq_addr_hold", imem.addr, 32'h0);
        imem.ack   = 1'b1;
        imem.rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_output("sq_no_valid", {31'b0, instr_valid_o}, 32'h0);
        check_output("sq_pc", pc_o, 32'hFFFF_FFF8);
        check_output("sq_new_req", {31'b0, imem.req}, 32'h1);

        // Redirect in the same cycle as an ack: data dropped, jump taken
        // from instr_pc 0xFFFF_FFFC (pcp4 wraps to 0) -> 0x100.
        imem.rdata = 32'hBAD0_0001;
        apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0, 26'h000_0040);
        @(negedge clk);
        imem.ack = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        check_output("ra_no_valid", {31'b0, instr_valid_o}, 32'h0);
        check_output("ra_pc", pc_o, 32'h100);
        check_output("ra_req", {31'b0, imem.req}, 32'h1);
        cur_pc = 32'h100;
`endif

        // Asynchronous reset with a request in flight; a late ack is ignored.
        check_output("ar_pre_addr", imem.addr, cur_pc);
        #2 reset = 1'b1;
        #1;
        check_output("ar_req_drop", {31'b0, imem.req}, 32'h0);
        check_output("ar_pc", pc_o, 32'h0);
        imem.ack   = 1'b1;
        imem.rdata = 32'h5A5A_5A5A;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_output("ar_idle_req", {31'b0, imem.req}, 32'h0);
        imem.ack = 1'b0;
        @(negedge clk);
        check_output("ar_late_ack", {31'b0, instr_valid_o}, 32'h0);
        check_output("ar_restart_req", {31'b0, imem.req}, 32'h1);
        check_output("ar_restart_addr", imem.addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
